// File: rtl/vga_fb_writer.sv
// Framebuffer write engine: turns PLOT/FILL/CLEAR commands into clipped, linear-address pixel writes.
// Latency: accept at edge T -> first write in cycle T+2, N writes back-to-back, done pulse in cycle T+N+2.
// Backpressure: cmd_ready_o is high only when idle; cmd_valid_i held during a command waits for the next idle cycle.
module vga_fb_writer #(
  parameter int FB_WIDTH   = 40,
  parameter int FB_HEIGHT  = 30,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 3,
  parameter int COORD_W    = 10
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [COORD_W-1:0]    cmd_x_i,
  input  logic [COORD_W-1:0]    cmd_y_i,
  input  logic [COORD_W-1:0]    cmd_w_i,
  input  logic [COORD_W-1:0]    cmd_h_i,
  input  logic [DATA_WIDTH-1:0] cmd_color_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_PLOT  = 2'd0;
  localparam logic [1:0] OP_FILL  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  // Coordinates carry one extra bit so x+w / y+h can never wrap.
  localparam int CW = COORD_W + 1;
  localparam logic [COORD_W:0]    ONE_C = CW'(1);
  localparam logic [COORD_W:0]    FBW_C = CW'(FB_WIDTH);
  localparam logic [COORD_W:0]    FBH_C = CW'(FB_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] FBW_A = ADDR_WIDTH'(FB_WIDTH);

  logic [1:0]            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [COORD_W-1:0]    x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic [COORD_W:0]      col_q, col_d, row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, row_base_q, row_base_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic [COORD_W:0]      eff_x, eff_y, eff_w, eff_h;
  logic [COORD_W:0]      x_sum, y_sum, x_end, y_end;
  logic                  void_op, empty;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  col_last, row_last;

  // Effective rectangle from the latched command, clipped to the screen.
  always_comb begin
    eff_x   = {1'b0, x_q};
    eff_y   = {1'b0, y_q};
    eff_w   = {1'b0, w_q};
    eff_h   = {1'b0, h_q};
    void_op = 1'b0;
    case (op_q)
      OP_PLOT: begin
        eff_w = ONE_C;
        eff_h = ONE_C;
      end
      OP_FILL: ;
      OP_CLEAR: begin
        eff_x = '0;
        eff_y = '0;
        eff_w = FBW_C;
        eff_h = FBH_C;
      end
      default: void_op = 1'b1;
    endcase
    x_sum      = eff_x + eff_w;
    y_sum      = eff_y + eff_h;
    x_end      = (x_sum > FBW_C) ? FBW_C : x_sum;
    y_end      = (y_sum > FBH_C) ? FBH_C : y_sum;
    empty      = void_op || (eff_x >= FBW_C) || (eff_y >= FBH_C) ||
                 (eff_w == '0) || (eff_h == '0);
    start_addr = ADDR_WIDTH'(eff_y) * FBW_A + ADDR_WIDTH'(eff_x);
    col_last   = (col_q == x_end - ONE_C);
    row_last   = (row_q == y_end - ONE_C);
  end

  // Next-state logic: command accept, setup, raster walk and completion pulse.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = wr_en_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          op_d    = cmd_op_i;
          x_d     = cmd_x_i;
          y_d     = cmd_y_i;
          w_d     = cmd_w_i;
          h_d     = cmd_h_i;
          color_d = cmd_color_i;
          state_d = S_SETUP;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_SETUP: begin
        if (empty) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = S_RUN;
          wr_en_d    = 1'b1;
          wr_data_d  = color_q;
          col_d      = eff_x;
          row_d      = eff_y;
          addr_d     = start_addr;
          row_base_d = start_addr;
        end
      end
      S_RUN: begin
        if (col_last && row_last) begin
          state_d = S_DONE;
          wr_en_d = 1'b0;
          done_d  = 1'b1;
        end else if (col_last) begin
          // Row wrap happens in the same cycle as the last write so the stream has no gaps.
          col_d      = eff_x;
          row_d      = row_q + ONE_C;
          row_base_d = row_base_q + FBW_A;
          addr_d     = row_base_q + FBW_A;
        end else begin
          col_d  = col_q + ONE_C;
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any command and drops wr_en at once.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
